// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Brief    : Shared types and constants for the game note scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int TICK_PERIOD_DEFAULT = 100000;

    // Song ROM entry layout: [15:8] note mask, [7:4] duration, [3:0] gap
    localparam int MASK_MSB = 15;
    localparam int MASK_LSB = 8;
    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 4;
    localparam int GAP_MSB  = 3;
    localparam int GAP_LSB  = 0;

    // Mask and duration both zero marks the end of the song
    localparam logic [11:0] END_MARKER = 12'h000;

    function automatic logic is_end_marker(input logic [15:0] entry);
        return entry[MASK_MSB:DUR_LSB] == END_MARKER;
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_note_scheduler_scroll_tick_gen.sv
// ============================================================================
// Module   : scroll_tick_gen
// Brief    : Free-running period counter with enable/clear; one-cycle tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scroll_tick_gen
    import game_pkg::*;
#(
    parameter int TICK_PERIOD = TICK_PERIOD_DEFAULT
) (
    input  logic vga_clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW       = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TICK_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over enable so a fresh note always gets a full first period
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == TERMINAL) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_note_scheduler.sv
// ============================================================================
// Module   : game_note_scheduler
// Brief    : Walks a song ROM, presenting note masks for duration/gap ticks.
//            Optional scoring enabled by defining GAME_SCORE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module game_note_scheduler
    import game_pkg::*;
#(
    parameter int TICK_PERIOD = TICK_PERIOD_DEFAULT,
    parameter int ROM_AW      = 8
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
`ifdef GAME_SCORE_EN
    input  logic [7:0]        key,
    input  logic [6:0]        bottom_mask,
    output logic [15:0]       score,
`endif
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        note,
    output logic              output_ready,
    output logic              tick,
    output logic              busy,
    output logic              song_done
);

    localparam logic [ROM_AW-1:0] LAST_ADDR = {ROM_AW{1'b1}};

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] addr_q,  addr_d;
    logic [7:0]        note_q,  note_d;
    logic              ready_q, ready_d;
    logic [3:0]        dur_q,   dur_d;
    logic [3:0]        gap_q,   gap_d;
    logic [3:0]        tcnt_q,  tcnt_d;

    logic w_active;
    logic w_tick_en;
    logic w_tick_clr;
    logic w_entry_done;

    assign w_active   = (state_q == ST_PLAY) || (state_q == ST_GAP);
    assign w_tick_en  = w_active && !pause && !start;
    assign w_tick_clr = start || (state_q == ST_LOAD);

    scroll_tick_gen #(
        .TICK_PERIOD (TICK_PERIOD)
    ) u_tick_gen (
        .vga_clk (vga_clk),
        .rst     (rst),
        .en      (w_tick_en),
        .clr     (w_tick_clr),
        .tick    (tick)
    );

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            ready_q <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            ready_q <= ready_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Tick only arrives in unpaused PLAY/GAP, so pause freezes everything here
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        note_d       = note_q;
        ready_d      = ready_q;
        dur_d        = dur_q;
        gap_d        = gap_q;
        tcnt_d       = tcnt_q;
        w_entry_done = 1'b0;

        if (start) begin
            state_d = ST_FETCH;
            addr_d  = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                ST_FETCH: state_d = ST_LOAD;
                ST_LOAD: begin
                    if (is_end_marker(rom_data)) begin
                        state_d = ST_DONE;
                        note_d  = '0;
                        ready_d = 1'b0;
                    end else begin
                        state_d = ST_PLAY;
                        note_d  = rom_data[MASK_MSB:MASK_LSB];
                        ready_d = 1'b1;
                        dur_d   = (rom_data[DUR_MSB:DUR_LSB] == 4'd0) ? 4'd1
                                                                      : rom_data[DUR_MSB:DUR_LSB];
                        gap_d   = rom_data[GAP_MSB:GAP_LSB];
                        tcnt_d  = '0;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (tcnt_q + 4'd1 == dur_q) begin
                            tcnt_d = '0;
                            if (gap_q != 4'd0) begin
                                state_d = ST_GAP;
                                note_d  = '0;
                                ready_d = 1'b1;
                            end else begin
                                w_entry_done = 1'b1;
                            end
                        end else begin
                            tcnt_d = tcnt_q + 4'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (tcnt_q + 4'd1 == gap_q) begin
                            tcnt_d       = '0;
                            w_entry_done = 1'b1;
                        end else begin
                            tcnt_d = tcnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = state_q;
            endcase

            // The last ROM slot ends the song rather than wrapping to 0
            if (w_entry_done) begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    note_d  = '0;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                    addr_d  = addr_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rom_addr     = addr_q;
        note         = note_q;
        output_ready = ready_q && !(w_active && pause);
        busy         = (state_q == ST_FETCH) || (state_q == ST_LOAD) || w_active;
        song_done    = (state_q == ST_DONE);
    end

`ifdef GAME_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [6:0]  w_key_row;
    logic        w_key_unused;

    // Keys are wired C..B from bit7 down; the display row is C..B from bit0 up
    assign w_key_row    = {key[1], key[2], key[3], key[4], key[5], key[6], key[7]};
    assign w_key_unused = key[0];

    always_comb begin
        score_d = score_q;
        if (start) begin
            score_d = '0;
        end else if (tick && (bottom_mask != 7'd0) && (bottom_mask == w_key_row)
                     && (score_q != 16'hFFFF)) begin
            score_d = score_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`endif

endmodule

`default_nettype wire

// File: doc/game_note_scheduler.md
GAME_NOTE_SCHEDULER -- requirements
Module: game_note_scheduler

Interface
REQ-001 SHALL have parameter TICK_PERIOD, default 100000, meaning vga_clk cycles per scroll tick (min 2).
REQ-002 SHALL have parameter ROM_AW, default 8, meaning song ROM address width.
REQ-003 SHALL have port vga_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports start  in  1 (pulse, begin/restart song) and pause  in  1 (level, freeze playback).
REQ-006 SHALL have ports rom_addr  out  ROM_AW (song ROM address) and rom_data  in  16 (entry: [15:8] note mask, [7:4] duration ticks, [3:0] gap ticks; ROM read latency 1 cycle).
REQ-007 SHALL have ports note  out  8 (note mask to display, bit0=C..bit6=B, bit7 unused) and output_ready  out  1 (note valid).
REQ-008 SHALL have ports tick  out  1 (one-cycle scroll strobe), busy  out  1, song_done  out  1.
REQ-009 SHALL, under GAME_SCORE_EN only, have ports key  in  8 (key[7]=C..key[1]=B), bottom_mask  in  7 (display bottom row, bit6=B..bit0=C), score  out  16.

Function
REQ-010 SHALL implement states IDLE, FETCH, LOAD, PLAY, GAP, DONE.
REQ-011 SHALL leave IDLE or DONE for FETCH with rom_addr=0 on the cycle after start=1.
REQ-012 SHALL drive rom_addr in FETCH and capture rom_data in LOAD exactly one cycle later.
REQ-013 SHALL treat an entry with note mask 0 and duration 0 as the end marker: LOAD -> DONE.
REQ-014 SHALL, in LOAD for a non-end entry, register note=mask, output_ready=1, go to PLAY; duration 0 is treated as 1.
REQ-015 SHALL generate tick every TICK_PERIOD cycles only in PLAY/GAP; tick counter restarts at 0 on entry to PLAY.
REQ-016 SHALL leave PLAY after the duration-th tick: to GAP if gap>0 (note=0, output_ready=1), else to FETCH at rom_addr+1.
REQ-017 SHALL leave GAP after the gap-th tick to FETCH at rom_addr+1.
REQ-018 SHALL go to DONE after the entry at address 2^ROM_AW-1 completes, with no address wrap.
REQ-019 SHALL, while pause=1 in PLAY/GAP, freeze state, tick counter and tick-count, hold tick=0 and output_ready=0; resume exactly where frozen.
REQ-020 SHALL ignore pause in IDLE, FETCH, LOAD, DONE.
REQ-021 SHALL, on start in any non-IDLE state (including paused), abandon playback and restart at FETCH, address 0; start wins over pause on the same cycle.
REQ-022 SHALL drive busy=1 in FETCH/LOAD/PLAY/GAP; song_done=1 only in DONE, with note=0, output_ready=0.
REQ-023 SHALL keep FETCH/LOAD to 2 cycles per entry with output_ready held at its previous value during them.

Reset
REQ-024 SHALL on rst=1 force IDLE, rom_addr=0, note=0, output_ready=0, tick=0, busy=0, song_done=0, counters=0, score=0.
REQ-025 SHALL give rst priority over start and pause; reset mid-song requires a new start.

Configuration
REQ-026 SHALL compile scoring when GAME_SCORE_EN is defined: on each tick in PLAY/GAP, if bottom_mask!=0 and bottom_mask=={key[1],key[2],key[3],key[4],key[5],key[6],key[7]}, score increments, saturating at 16'hFFFF; score clears on start.
REQ-027 SHALL, without GAME_SCORE_EN, omit key, bottom_mask, score ports and all scoring logic; other behaviour identical.

Structure
REQ-028 SHALL take state enum, entry field bit positions, end-marker encoding and default TICK_PERIOD from shared package game_pkg.
REQ-029 SHALL instantiate one sub-module scroll_tick_gen (counter with enable/clear, emits tick).

Verification (TICK_PERIOD=4, ROM_AW=2)
REQ-030 SHALL check: ROM {16'h0121,16'h0210,16'h0000}, start -> note=01 for 2 ticks, 0 for 1 tick, note=02 for 1 tick, then song_done=1, busy=0.
REQ-031 SHALL check: pause=1 for 10 cycles mid-PLAY -> tick=0, output_ready=0, remaining ticks unchanged after release.
REQ-032 SHALL check: start during GAP of entry 1 -> rom_addr=0 two cycles earlier than completion, score=0.
REQ-033 SHALL check: 4 non-end entries {16'h4010} -> DONE after entry 3, rom_addr never returns to 0.
REQ-034 SHALL check: rst=1 mid-PLAY -> all outputs 0 next cycle, IDLE until start.
REQ-035 SHALL check (GAME_SCORE_EN): bottom_mask=7'b0000001, key=8'h80 on 3 ticks -> score=3; bottom_mask=0 with key=0 -> no increment.
